// File: rtl/uart_ram_loader.sv
// uart_ram_loader: decodes a UART byte protocol into 32-bit RAM port B writes and read-back streams
module uart_ram_loader #(
  parameter int LINES          = 8192,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(LINES)-1:0] addr_b,
  output logic                     en_b,
  output logic [3:0]               be_b,
  output logic [31:0]              data_in_b,
  input  logic [31:0]              data_out_b,
  output logic                     busy,
  output logic                     error
);
  localparam int AW = $clog2(LINES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, HDR, WR_DATA, WR_COMMIT, RD_ISSUE, RD_WAIT, RD_SEND, RESP} state_t;
  state_t r_state, w_next;
  logic [1:0] r_cnt;
  logic [23:0] r_hdr;
  logic [31:0] r_word, w_hdr;
  logic [AW-1:0] r_addr, w_addr_inc;
  logic [15:0] r_len;
  logic [TW-1:0] r_tmo;
  logic [7:0] r_resp;
  logic r_is_wr, r_error, w_cmd_ok, w_rx_state, w_tmo, w_hs;
  assign w_hdr      = {rx_data, r_hdr};
  assign w_cmd_ok   = rx_data == 8'h57 || rx_data == 8'h52;
  assign w_rx_state = r_state == HDR || r_state == WR_DATA;
  assign w_tmo      = w_rx_state && !rx_valid && r_tmo == TW'(TIMEOUT_CYCLES - 1);
  assign w_hs       = tx_valid && tx_ready;
  assign w_addr_inc = r_addr == AW'(LINES - 1) ? '0 : r_addr + 1'b1;
  assign en_b       = r_state == WR_COMMIT || r_state == RD_ISSUE;
  assign be_b       = r_state == WR_COMMIT ? 4'hF : 4'h0;
  assign addr_b     = r_addr;
  assign data_in_b  = r_word;
  assign tx_valid   = r_state == RD_SEND || r_state == RESP;
  assign tx_data    = r_state == RD_SEND ? r_word[{r_cnt, 3'b000} +: 8] : r_state == RESP ? r_resp : 8'h00;
  assign busy       = r_state != IDLE;
  assign error      = r_error;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = rx_valid ? (w_cmd_ok ? HDR : RESP) : IDLE;
      HDR:       w_next = w_tmo ? RESP : !(rx_valid && r_cnt == 2'd3) ? HDR :
                          r_is_wr ? (w_hdr[31:16] == 16'd0 ? RESP : WR_DATA) :
                          (w_hdr[31:16] == 16'd0 ? IDLE : RD_ISSUE);
      WR_DATA:   w_next = w_tmo ? RESP : (rx_valid && r_cnt == 2'd3) ? WR_COMMIT : WR_DATA;
      WR_COMMIT: w_next = r_len == 16'd1 ? RESP : WR_DATA;
      RD_ISSUE:  w_next = RD_WAIT;
      RD_WAIT:   w_next = RD_SEND;
      RD_SEND:   w_next = (w_hs && r_cnt == 2'd3) ? (r_len == 16'd1 ? IDLE : RD_ISSUE) : RD_SEND;
      RESP:      w_next = w_hs ? IDLE : RESP;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hdr   <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_tmo   <= '0;
      r_resp  <= '0;
      r_is_wr <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmo   <= (rx_valid || !w_rx_state) ? '0 : r_tmo + 1'b1;
      case (r_state)
        IDLE: if (rx_valid) begin
          r_is_wr <= rx_data == 8'h57;
          r_error <= !w_cmd_ok;
          r_resp  <= 8'h45;
          r_cnt   <= '0;
        end
        HDR, WR_DATA: if (w_tmo) begin
          r_error <= 1'b1;
          r_resp  <= 8'h45;
          r_cnt   <= '0;
        end else if (rx_valid) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_state == WR_DATA) r_word <= {rx_data, r_word[31:8]};
          else r_hdr <= w_hdr[31:8];
          if (r_state == HDR && r_cnt == 2'd3) begin
            r_addr <= AW'(w_hdr[15:0]);
            r_len  <= w_hdr[31:16];
            r_resp <= 8'h4B;
          end
        end
        WR_COMMIT: begin
          r_addr <= w_addr_inc;
          r_len  <= r_len - 1'b1;
        end
        RD_WAIT: begin
          r_word <= data_out_b;
          r_cnt  <= '0;
        end
        RD_SEND: if (w_hs) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == 2'd3) begin
            r_addr <= w_addr_inc;
            r_len  <= r_len - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_ram_loader.sv
// tb_uart_ram_loader: directed packets with tx/write scoreboards against a behavioural RAM
module tb_uart_ram_loader;
  localparam int LINES = 8192;
  localparam int AW    = 13;
  localparam int TMO   = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [AW-1:0] addr_b;
  logic en_b;
  logic [3:0] be_b;
  logic [31:0] data_in_b;
  logic [31:0] data_out_b = '0;
  logic busy, error;
  int n_assert = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int stall = 0;
  logic [7:0] txq[$];
  logic [AW+31:0] wq[$];
  logic [31:0] mem [LINES];

  always #5 clk = ~clk;

  uart_ram_loader #(.LINES(LINES), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .addr_b(addr_b), .en_b(en_b), .be_b(be_b), .data_in_b(data_in_b),
    .data_out_b(data_out_b), .busy(busy), .error(error)
  );

  always @(posedge clk) if (en_b) begin
    for (int b = 0; b < 4; b++) if (be_b[b]) mem[addr_b][8*b +: 8] <= data_in_b[8*b +: 8];
    data_out_b <= mem[addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // tx_ready is held low for `stall` cycles of each byte, then raised for one cycle
  initial begin
    int sc;
    sc = 0;
    tx_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!tx_valid || tx_ready) begin
        tx_ready = 1'b0;
        sc = 0;
      end else if (sc >= stall) tx_ready = 1'b1;
      else sc++;
    end
  end

  initial begin
    logic pv, ph, hs;
    logic [7:0] pd;
    logic [AW+31:0] e;
    pv = 1'b0; ph = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!en_b && be_b != 4'h0) check("be_without_en", {28'd0, be_b}, 32'd0);
      if (en_b && be_b == 4'hF) begin
        check("write_expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check("wr_addr", {19'd0, addr_b}, {19'd0, e[AW+31:32]});
          check("wr_data", data_in_b, e[31:0]);
        end
      end
      if (en_b && be_b == 4'h0) rd_cnt++;
      if (tx_valid && pv && !ph) check("tx_stable", {24'd0, tx_data}, {24'd0, pd});
      hs = tx_valid && tx_ready;
      if (hs) begin
        check("tx_expected", 32'(txq.size() > 0), 32'd1);
        if (txq.size() > 0) check("tx_byte", {24'd0, tx_data}, {24'd0, txq.pop_front()});
      end
      pv = tx_valid; ph = hs; pd = tx_data;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] p[$]);
    foreach (p[i]) send(p[i]);
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      if (!busy && txq.size() == 0 && wq.size() == 0) break;
    end
    check({tag, "_done"}, 32'(i < 3000), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pkt[$];
    int i;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_en_b", {31'd0, en_b}, 32'd0);
    check("rst_be_b", {28'd0, be_b}, 32'd0);
    check("rst_addr_b", {19'd0, addr_b}, 32'd0);
    check("rst_data_in_b", data_in_b, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    rst = 1'b0;

    wq.push_back({13'h0010, 32'hAABBCCDD});
    wq.push_back({13'h0011, 32'h11223344});
    txq.push_back(8'h4B);
    pkt = '{8'h57, 8'h10, 8'h00, 8'h02, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    send_bytes(pkt);
    wait_done("write");

    stall = 3;
    rd_cnt = 0;
    pkt = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
    foreach (pkt[k]) txq.push_back(pkt[k]);
    pkt = '{8'h52, 8'h10, 8'h00, 8'h02, 8'h00};
    send_bytes(pkt);
    wait_done("read");
    check("read_issues", rd_cnt, 32'd2);
    stall = 0;

    wq.push_back({13'h1FFF, 32'h04030201});
    wq.push_back({13'h0000, 32'h08070605});
    txq.push_back(8'h4B);
    pkt = '{8'h57, 8'hFF, 8'h1F, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_bytes(pkt);
    wait_done("wrap");

    txq.push_back(8'h45);
    send(8'h99);
    wait_done("badcmd");
    check("badcmd_error", {31'd0, error}, 32'd1);
    rd_cnt = 0;
    send(8'h52);
    #1;
    check("cmd_clears_error", {31'd0, error}, 32'd0);
    check("cmd_busy", {31'd0, busy}, 32'd1);
    pkt = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(pkt);
    wait_done("read_n0");
    check("read_n0_issues", rd_cnt, 32'd0);

    txq.push_back(8'h45);
    pkt = '{8'h57, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_bytes(pkt);
    for (i = 1; i <= 200; i++) begin
      @(negedge clk);
      #2;
      if (tx_valid) break;
    end
    check("tmo_latency", i, TMO);
    check("tmo_error", {31'd0, error}, 32'd1);
    wait_done("timeout");

    pkt = '{8'h57, 8'h20, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
    send_bytes(pkt);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_en_b", {31'd0, en_b}, 32'd0);
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_error", {31'd0, error}, 32'd0);
    check("midrst_data_in_b", data_in_b, 32'd0);
    rst = 1'b0;
    wq.push_back({13'h0020, 32'h44332211});
    txq.push_back(8'h4B);
    pkt = '{8'h57, 8'h20, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_bytes(pkt);
    wait_done("after_rst");

    check("txq_empty", txq.size(), 32'd0);
    check("wq_empty", wq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Host-side loader that sits directly upstream of port B of the dual-port byte-enable program/data RAM.
- Consumes a byte stream from the UART receiver and decodes a small command protocol.
- Writes assembled 32-bit words into the RAM, or reads words back and streams their bytes to the UART transmitter.
- Port A remains owned by the core; this block drives only port B.

Parameters:
- LINES, 8192: RAM depth in 32-bit words; address width is $clog2(LINES).
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between rx bytes inside a packet before the packet is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe per received byte; no backpressure
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx byte valid
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&&tx_ready
- addr_b  out  $clog2(LINES)  RAM port B word address
- en_b  out  1  RAM port B enable
- be_b  out  4  RAM port B byte enables; 0 = read
- data_in_b  out  32  RAM port B write data
- data_out_b  in  32  RAM port B read data, valid the cycle after the read request
- busy  out  1  high whenever state != IDLE
- error  out  1  sticky; set on bad command or timeout; cleared by the next valid command byte or by rst

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0; no RAM access in the cycle after the reset edge.
- Packet format: cmd byte, then ADDR_LO, ADDR_HI, LEN_LO, LEN_HI (little-endian word address and word count N). Write commands are followed by 4N data bytes, LSB first.
- Command codes: 0x57 = write, 0x52 = read. Any other cmd byte in IDLE sets error, queues response 0x45 and returns to IDLE.
- Address handling: the address is truncated to $clog2(LINES) bits. Each increment wraps modulo LINES (LINES-1 -> 0).
- States:
  - IDLE
  - HDR: collects 4 bytes.
  - WR_DATA: assembles data bytes.
  - WR_COMMIT: en_b=1, be_b=4'hF, addr_b=current address, data_in_b=assembled word, exactly one cycle, entered the cycle after the 4th byte of a word is accepted. Then address+1 and remaining-1; go to WR_DATA, or RESP if remaining=0.
  - RD_ISSUE: en_b=1, be_b=0 for one cycle.
  - RD_WAIT: one cycle; capture data_out_b at its end.
  - RD_SEND: emit the 4 captured bytes LSB first, each held stable with tx_valid high until tx_ready. Then address+1; go to RD_ISSUE, or IDLE when the count is exhausted.
  - RESP: hold tx_data=0x4B ('K') for write completion, or 0x45 ('E') for an error, until accepted; then IDLE.
- N=0: write goes HDR->RESP ('K') with no RAM access; read goes HDR->IDLE with no tx bytes.
- rx bytes arriving in WR_COMMIT, RD_*, or RESP are dropped silently. A rx_valid coinciding with the WR_COMMIT cycle is also dropped; the host must pace.
- en_b is 0 in every state except WR_COMMIT and RD_ISSUE; be_b is 0 whenever en_b=0.
- Timeout:
  - Applies only in HDR and WR_DATA.
  - The counter resets on every rx_valid.
  - Reaching TIMEOUT_CYCLES discards any partial word with no RAM write, sets error, and goes to RESP with 0x45.
- Reset mid-operation: the packet is abandoned, a partially assembled word is never written, and tx_valid drops at the next edge.
- A valid cmd byte (0x57/0x52) in IDLE clears error in the same cycle it is accepted.

Test Plan:
- Write: 57 10 00 02 00 + DD CC BB AA 44 33 22 11 -> two WR_COMMIT cycles: addr 0x10 with 0xAABBCCDD, then addr 0x11 with 0x11223344, be_b=F; then tx 0x4B.
- Read back: 52 10 00 02 00 with tx_ready stalled 3 cycles per byte -> tx bytes DD CC BB AA 44 33 22 11; tx_data is stable during each stall; en_b pulses once per word with be_b=0.
- Wrap: write at address 0x1FFF with N=2, LINES=8192 -> commits to 0x1FFF then 0x0000.
- Bad command: byte 0x99 -> error=1, tx 0x45; a following 0x52 clears error.
- Timeout: TIMEOUT_CYCLES=50; send 57 00 00 01 00 AA BB, then silence -> after 50 cycles tx 0x45, error=1, no en_b asserted.
- Reset mid-write after 2 data bytes -> no RAM write, outputs 0, busy=0; a subsequent full packet succeeds.
